pre_i_blk8_pack: RTL and testbench
==================================

Name: pre_i_blk8_pack

Overview:
- Upstream feeder for the pre-intra 8x8 block buffers: 32-bit words, 16 entries, two-port RF.
- Accepts a raster-order stream of 8x8 original pixels over a valid/ready handshake.
- Packs 4 pixels per 32-bit word and writes each 64-pixel block into one of two ping-pong 32x16 banks.
- Tracks per-bank full/free status so the mode-decision consumer can read one bank while the other fills.

Parameters:
- PIX_W, 8, pixel bit width; word width is 4*PIX_W.
- ADDR_W, 4, bank word-address width; 16 words per block.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- pix_i  input  PIX_W  pixel, 8x8 raster order (row 0 col 0 first)
- pix_val_i  input  1  pixel valid
- pix_rdy_o  output  1  pixel ready; transfer occurs when pix_val_i & pix_rdy_o
- flush_i  input  1  abort the partially filled block
- we_o  output  2  per-bank write enable (bit b -> bank b), drives bank RF we
- waddr_o  output  ADDR_W  word address, shared by both banks
- wdata_o  output  4*PIX_W  packed word, shared by both banks
- full_o  output  2  bank b holds a complete block
- rel_i  input  2  one-cycle pulse per bank; consumer has finished bank b
- done_o  output  1  one-cycle pulse when a block completes
- done_bank_o  output  1  bank index qualified by done_o

Behaviour:
- Reset (rst=1 at a clk edge) clears the following. Outputs: we_o=0, waddr_o=0, wdata_o=0, full_o=0, done_o=0, done_bank_o=0. Internal: pixel counter=0, write bank=0, pack register=0.
  - Reset applies mid-block and mid-stall; the partial block is discarded. Reset has priority over every other input.
- pix_rdy_o = ~rst & ~full_o[wbank] & ~flush_i. This is combinational from registered state and flush_i.
- Pixel counter pcnt is 6 bits. On each transfer, the pixel is placed in pack lane 3-pcnt[1:0]:
  - lane 3 = bits [4*PIX_W-1:3*PIX_W], so the first pixel is the MSB byte.
  - pcnt increments, wrapping 63->0.
- Write timing: when the transfer has pcnt[1:0]==3, then on the next cycle:
  - we_o[wbank]=1 for exactly one cycle;
  - waddr_o=pcnt[5:2] of that transfer (word = row*2 + half-row);
  - wdata_o holds the completed 4 pixels.
  - Write latency is 1 cycle after the 4th pixel's accept edge.
- Block completion: the transfer with pcnt==63 completes a block. In the cycle the final write is issued (we_o high):
  - done_o=1 and done_bank_o=wbank;
  - full_o[wbank] rises at the end of that cycle, coincident with the RF write edge;
  - wbank toggles at the same edge.
- FSM, 2 states:
  - FILL: accepting. Go to STALL when wbank toggles onto a full bank, or when the current bank is full.
  - STALL: pix_rdy_o=0. Return to FILL on the cycle after full_o[wbank] clears.
- Release: rel_i[b] clears full_o[b] at the next edge.
  - Release of a non-full bank is ignored.
  - rel_i[b] and a same-cycle set of full on bank b cannot both act, because only a non-full bank is written. If both occur, set wins.
  - rel_i = 2'b11 clears both banks.
- Back-to-back: with both banks free and pix_val_i held high, throughput is 1 pixel/cycle.
  - Block k+1 pixel 0 is accepted in the cycle after block k pixel 63.
  - The final write of block k and the first pixels of block k+1 overlap without stall.
- flush_i=1:
  - pcnt and pack register clear at the edge; no transfer is accepted that cycle.
  - A write already pending (we_o in the following cycle) still issues.
  - Banks, wbank and full_o are unchanged; no done_o.
- No transfer while pix_val_i=0; pcnt holds. Gaps between pixels are allowed anywhere.
- No combinational path from pix_val_i to any output other than via registers.

Test Plan:
- Reset, then stream pixels 0x00..0x3F at 1/cycle:
  - 16 writes to bank 0, waddr 0..15, first wdata=0x00010203, last=0x3C3D3E3F;
  - done_o with done_bank_o=0; full_o=01; pix_rdy_o stays 1.
- Stream 3 blocks with no release:
  - blocks 0 and 1 fill banks 0 and 1, full_o=11, pix_rdy_o=0 after pixel 127;
  - rel_i=01 -> pix_rdy_o=1 two cycles later, block 2 written to bank 0.
- Random pix_val_i gaps (50%) over 4 blocks with immediate release after each done_o:
  - every written word matches the reference packing; exactly 64 writes; banks alternate 0,1,0,1.
- Assert flush_i after 10 pixels, then stream 64 new pixels:
  - block starts at waddr 0 with the new pixels in bank 0;
  - words 0-1 written pre-flush are overwritten; no done_o for the aborted block.
- Assert rst after 37 pixels while full_o=10:
  - next cycle full_o=00, we_o=00, pcnt=0, and the next block goes to bank 0.
- Pulse rel_i=10 while full_o=00: no state change. Then rel_i=11 with full_o=11: full_o=00 next cycle.

Source files
------------

// File: rtl/pre_i_blk8_pack_if.sv
`default_nettype none
// ============================================================================
//  Module      : pre_i_blk8_pack_if
//  Description : Pixel-stream and bank-write bundle for the pre-intra 8x8
//                block packer. The master side drives the pixel stream and
//                the bank releases. The slave side is the packer.
//  Revision    : 1.0  initial release
// ============================================================================
interface pre_i_blk8_pack_if #(
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 4
);
    logic [PIX_W-1:0]   pix_i;
    logic               pix_val_i;
    logic               pix_rdy_o;
    logic               flush_i;
    logic [1:0]         we_o;
    logic [ADDR_W-1:0]  waddr_o;
    logic [4*PIX_W-1:0] wdata_o;
    logic [1:0]         full_o;
    logic [1:0]         rel_i;
    logic               done_o;
    logic               done_bank_o;

    modport master (
        output pix_i, pix_val_i, flush_i, rel_i,
        input  pix_rdy_o, we_o, waddr_o, wdata_o, full_o, done_o, done_bank_o
    );

    modport slave (
        input  pix_i, pix_val_i, flush_i, rel_i,
        output pix_rdy_o, we_o, waddr_o, wdata_o, full_o, done_o, done_bank_o
    );
endinterface
`default_nettype wire

// File: rtl/pre_i_blk8_pack.sv
`default_nettype none
// ============================================================================
//  Module      : pre_i_blk8_pack
//  Description : Packs a raster 8x8 pixel stream four pixels per word and
//                writes whole blocks into two ping-pong RF banks, tracking
//                which banks hold a complete block awaiting the consumer.
//  Revision    : 1.0  initial release
// ============================================================================
module pre_i_blk8_pack #(
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    pre_i_blk8_pack_if.slave   bus
);

    localparam int                WORD_W   = 4 * PIX_W;
    localparam int                CNT_W    = ADDR_W + 2;
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_LAST = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    pcnt_q, pcnt_d;
    logic [WORD_W-1:0]   pack_q, pack_d, pack_ins;
    logic                wbank_q, wbank_d;
    logic [1:0]          we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic [1:0]          full_q, full_d;
    logic                done_q, done_d;
    logic                done_bank_q, done_bank_d;
    logic                pix_rdy;
    logic                xfer;

    // Ready depends only on registered state, reset and flush, never on valid.
    assign pix_rdy = ~rst & ~full_q[wbank_q] & ~bus.flush_i & (state_q == ST_FILL);
    assign xfer    = bus.pix_val_i & pix_rdy;

    assign bus.pix_rdy_o   = pix_rdy;
    assign bus.we_o        = we_q;
    assign bus.waddr_o     = waddr_q;
    assign bus.wdata_o     = wdata_q;
    assign bus.full_o      = full_q;
    assign bus.done_o      = done_q;
    assign bus.done_bank_o = done_bank_q;

    // Drop the incoming pixel into its lane; the first pixel of a word is the MSB.
    always_comb begin
        pack_ins = pack_q;
        case (pcnt_q[1:0])
            2'd0:    pack_ins[4*PIX_W-1:3*PIX_W] = bus.pix_i;
            2'd1:    pack_ins[3*PIX_W-1:2*PIX_W] = bus.pix_i;
            2'd2:    pack_ins[2*PIX_W-1:PIX_W]   = bus.pix_i;
            default: pack_ins[PIX_W-1:0]         = bus.pix_i;
        endcase
    end

    // Datapath next state: counting, packing, write issue and bank bookkeeping.
    always_comb begin
        pcnt_d      = pcnt_q;
        pack_d      = pack_q;
        we_d        = 2'b00;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        done_d      = 1'b0;
        done_bank_d = done_bank_q;
        wbank_d     = wbank_q;
        // Release first, so a set in the same cycle wins.
        full_d      = full_q & ~bus.rel_i;

        // The final write of a block is on the bus now: the bank becomes
        // full at this edge, and filling moves to the other bank.
        if (done_q) begin
            full_d[wbank_q] = 1'b1;
            wbank_d         = ~wbank_q;
        end

        if (bus.flush_i) begin
            pcnt_d = '0;
            pack_d = '0;
        end else if (xfer) begin
            pcnt_d = pcnt_q + CNT_ONE;
            pack_d = pack_ins;
            if (pcnt_q[1:0] == 2'd3) begin
                we_d[wbank_d] = 1'b1;
                waddr_d       = pcnt_q[CNT_W-1:2];
                wdata_d       = pack_ins;
                if (pcnt_q == CNT_LAST) begin
                    done_d      = 1'b1;
                    done_bank_d = wbank_d;
                end
            end
        end
    end

    // Stall control: hold off the stream while the bank being filled is full.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL:  if (full_d[wbank_d])  state_d = ST_STALL;
            ST_STALL: if (!full_q[wbank_q]) state_d = ST_FILL;
            default:  state_d = ST_FILL;
        endcase
    end

    // State registers; reset discards any partial block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FILL;
            pcnt_q      <= '0;
            pack_q      <= '0;
            wbank_q     <= 1'b0;
            we_q        <= 2'b00;
            waddr_q     <= '0;
            wdata_q     <= '0;
            full_q      <= 2'b00;
            done_q      <= 1'b0;
            done_bank_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pcnt_q      <= pcnt_d;
            pack_q      <= pack_d;
            wbank_q     <= wbank_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            full_q      <= full_d;
            done_q      <= done_d;
            done_bank_q <= done_bank_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pre_i_blk8_pack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pre_i_blk8_pack
//  Description : Directed self-checking bench for the 8x8 block packer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pre_i_blk8_pack;

    localparam int PIX_W  = 8;
    localparam int ADDR_W = 4;

    logic clk;
    logic rst;
    int   cyc;
    int   n_vec;
    int   n_err;

    logic [7:0]  src [0:255];
    logic [1:0]  wr_we   [$];
    logic [3:0]  wr_addr [$];
    logic [31:0] wr_data [$];
    int          wr_cyc  [$];
    logic        done_b  [$];
    int          acc_cyc [$];
    logic [31:0] mem [0:1][0:15];

    pre_i_blk8_pack_if #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) ifc ();

    pre_i_blk8_pack #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bank RF model and write/done log, sampled mid-cycle.
    always @(negedge clk) begin
        if (ifc.we_o != 2'b00) begin
            wr_we.push_back(ifc.we_o);
            wr_addr.push_back(ifc.waddr_o);
            wr_data.push_back(ifc.wdata_o);
            wr_cyc.push_back(cyc);
            if (ifc.we_o[0]) mem[0][ifc.waddr_o] = ifc.wdata_o;
            if (ifc.we_o[1]) mem[1][ifc.waddr_o] = ifc.wdata_o;
        end
        if (ifc.done_o) done_b.push_back(ifc.done_bank_o);
    end

    function automatic logic [31:0] exp_word(input int w);
        return {src[4*w], src[4*w+1], src[4*w+2], src[4*w+3]};
    endfunction

    task automatic clear_logs();
        wr_we.delete(); wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        done_b.delete(); acc_cyc.delete();
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 16; a++) mem[b][a] = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; ifc.pix_val_i = 1'b0; ifc.flush_i = 1'b0; ifc.rel_i = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        clear_logs();
    endtask

    // Offer src[0..n-1]; gap_pct percent of cycles idle; optional release of
    // each bank the cycle after its done pulse; four idle cycles at the end.
    task automatic send(input int n, input int gap_pct, input bit auto_rel,
                        output int stalls, output bit timeout);
        int sent, used, tail;
        bit rel_pend;
        logic [1:0] rel_mask;
        sent = 0; used = 0; tail = 0; stalls = 0; rel_pend = 1'b0; rel_mask = 2'b00;
        while ((sent < n || tail < 4) && used < 4000) begin
            @(negedge clk);
            used++;
            ifc.rel_i = rel_pend ? rel_mask : 2'b00;
            rel_pend  = 1'b0;
            if (auto_rel && ifc.done_o) begin
                rel_pend = 1'b1;
                rel_mask = ifc.done_bank_o ? 2'b10 : 2'b01;
            end
            if (sent < n) begin
                ifc.pix_val_i = ($urandom_range(0, 99) >= gap_pct);
                ifc.pix_i     = src[sent];
            end else begin
                ifc.pix_val_i = 1'b0;
                tail++;
            end
            #1;
            if (ifc.pix_val_i && !ifc.pix_rdy_o) stalls++;
            if (ifc.pix_val_i && ifc.pix_rdy_o) begin
                acc_cyc.push_back(cyc);
                sent++;
            end
        end
        timeout = (sent < n);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; ifc.pix_val_i = 1'b1; ifc.pix_i = 8'hFF;
        ifc.flush_i = 1'b0; ifc.rel_i = 2'b00;
        @(negedge clk);
        @(negedge clk);
        n_vec++; if (ifc.we_o !== 2'b00) begin n_err++; $display("FAIL reset_we got=%b exp=00", ifc.we_o); end
        n_vec++; if (ifc.waddr_o !== 4'h0 || ifc.wdata_o !== 32'h0) begin n_err++;
            $display("FAIL reset_wbus got=%h/%h exp=0/0", ifc.waddr_o, ifc.wdata_o); end
        n_vec++; if (ifc.full_o !== 2'b00) begin n_err++; $display("FAIL reset_full got=%b exp=00", ifc.full_o); end
        n_vec++; if (ifc.done_o !== 1'b0 || ifc.done_bank_o !== 1'b0) begin n_err++;
            $display("FAIL reset_done got=%b/%b exp=0/0", ifc.done_o, ifc.done_bank_o); end
        n_vec++; if (ifc.pix_rdy_o !== 1'b0) begin n_err++; $display("FAIL reset_rdy got=%b exp=0", ifc.pix_rdy_o); end
        rst = 1'b0; ifc.pix_val_i = 1'b0;
        #1;
        n_vec++; if (ifc.pix_rdy_o !== 1'b1) begin n_err++; $display("FAIL reset_rdy_after got=%b exp=1", ifc.pix_rdy_o); end
        clear_logs();
    endtask

    task automatic test_one_block();
        int st; bit to;
        do_reset();
        for (int i = 0; i < 256; i++) src[i] = 8'(i);
        send(64, 0, 1'b0, st, to);
        n_vec++; if (to || st != 0) begin n_err++; $display("FAIL one_stall got=%0d/%0d exp=0/0", st, to); end
        n_vec++; if (wr_we.size() != 16) begin n_err++; $display("FAIL one_nwr got=%0d exp=16", wr_we.size()); end
        for (int i = 0; i < 16 && i < wr_we.size(); i++) begin
            n_vec++;
            if (wr_we[i] !== 2'b01 || wr_addr[i] !== 4'(i) || wr_data[i] !== exp_word(i)) begin
                n_err++;
                $display("FAIL one_word%0d got=%b/%h/%h exp=01/%h/%h", i, wr_we[i], wr_addr[i], wr_data[i], i, exp_word(i));
            end
        end
        n_vec++; if (wr_data.size() != 16 || wr_data[0] !== 32'h00010203 || wr_data[15] !== 32'h3C3D3E3F) begin
            n_err++; $display("FAIL one_endwords got_n=%0d exp=00010203..3C3D3E3F", wr_data.size()); end
        n_vec++; if (wr_cyc.size() == 0 || acc_cyc.size() < 4 || wr_cyc[0] != acc_cyc[3] + 1) begin
            n_err++; $display("FAIL one_latency got_wr=%0d exp=accept+1", wr_cyc.size() ? wr_cyc[0] : -1); end
        n_vec++; if (done_b.size() != 1 || done_b[0] !== 1'b0) begin n_err++;
            $display("FAIL one_done got_n=%0d exp=1 on bank 0", done_b.size()); end
        n_vec++; if (ifc.full_o !== 2'b01) begin n_err++; $display("FAIL one_full got=%b exp=01", ifc.full_o); end
    endtask

    task automatic test_no_release();
        int st; bit to;
        do_reset();
        for (int i = 0; i < 256; i++) src[i] = 8'(i);
        send(128, 0, 1'b0, st, to);
        n_vec++; if (to || st != 0) begin n_err++; $display("FAIL b2b_stall got=%0d/%0d exp=0/0", st, to); end
        n_vec++; if (acc_cyc.size() < 65 || acc_cyc[64] != acc_cyc[63] + 1) begin n_err++;
            $display("FAIL b2b_gap got_n=%0d exp=next-cycle accept", acc_cyc.size()); end
        n_vec++; if (wr_we.size() != 32 || wr_we[0] !== 2'b01 || wr_we[16] !== 2'b10) begin n_err++;
            $display("FAIL b2b_banks got_n=%0d exp=32 (bank0 then bank1)", wr_we.size()); end
        @(negedge clk); @(negedge clk);
        n_vec++; if (ifc.full_o !== 2'b11 || ifc.pix_rdy_o !== 1'b0) begin n_err++;
            $display("FAIL b2b_full got=%b/%b exp=11/0", ifc.full_o, ifc.pix_rdy_o); end
        @(negedge clk); ifc.rel_i = 2'b01;
        @(negedge clk); ifc.rel_i = 2'b00;
        #1;
        n_vec++; if (ifc.full_o !== 2'b10 || ifc.pix_rdy_o !== 1'b0) begin n_err++;
            $display("FAIL rel1_cycle1 got=%b/%b exp=10/0", ifc.full_o, ifc.pix_rdy_o); end
        @(negedge clk); #1;
        n_vec++; if (ifc.pix_rdy_o !== 1'b1) begin n_err++; $display("FAIL rel1_cycle2_rdy got=%b exp=1", ifc.pix_rdy_o); end
        clear_logs();
        for (int i = 0; i < 256; i++) src[i] = 8'(8'h80 + i);
        send(64, 0, 1'b0, st, to);
        n_vec++; if (to || wr_we.size() != 16) begin n_err++; $display("FAIL blk2_nwr got=%0d exp=16", wr_we.size()); end
        for (int i = 0; i < 16 && i < wr_we.size(); i++) begin
            n_vec++;
            if (wr_we[i] !== 2'b01 || wr_addr[i] !== 4'(i) || wr_data[i] !== exp_word(i)) begin
                n_err++;
                $display("FAIL blk2_word%0d got=%b/%h/%h exp=01/%h/%h", i, wr_we[i], wr_addr[i], wr_data[i], i, exp_word(i));
            end
        end
        n_vec++; if (ifc.full_o !== 2'b11 || done_b.size() != 1 || done_b[0] !== 1'b0) begin n_err++;
            $display("FAIL blk2_done got=%b/%0d exp=11/1 on bank 0", ifc.full_o, done_b.size()); end
    endtask

    task automatic test_random_gaps();
        int st; bit to;
        do_reset();
        for (int i = 0; i < 256; i++) src[i] = 8'($urandom);
        send(256, 50, 1'b1, st, to);
        n_vec++; if (to) begin n_err++; $display("FAIL rnd_timeout got=%0d exp=256 accepted", acc_cyc.size()); end
        n_vec++; if (wr_we.size() != 64) begin n_err++; $display("FAIL rnd_nwr got=%0d exp=64", wr_we.size()); end
        for (int i = 0; i < 64 && i < wr_we.size(); i++) begin
            n_vec++;
            if (wr_we[i] !== (((i / 16) % 2) ? 2'b10 : 2'b01) || wr_addr[i] !== 4'(i % 16) || wr_data[i] !== exp_word(i)) begin
                n_err++;
                $display("FAIL rnd_word%0d got=%b/%h/%h exp=bank%0d/%h/%h", i, wr_we[i], wr_addr[i], wr_data[i],
                         (i / 16) % 2, i % 16, exp_word(i));
            end
        end
        n_vec++; if (done_b.size() != 4 || done_b[0] !== 1'b0 || done_b[1] !== 1'b1 ||
                     done_b[2] !== 1'b0 || done_b[3] !== 1'b1) begin
            n_err++; $display("FAIL rnd_done got_n=%0d exp=4 alternating 0101", done_b.size()); end
    endtask

    task automatic test_flush();
        int st; bit to;
        do_reset();
        for (int i = 0; i < 256; i++) src[i] = 8'(8'hA0 + i);
        send(10, 0, 1'b0, st, to);
        @(negedge clk);
        ifc.flush_i = 1'b1; ifc.pix_val_i = 1'b1; ifc.pix_i = 8'h55;
        #1;
        n_vec++; if (ifc.pix_rdy_o !== 1'b0) begin n_err++; $display("FAIL flush_rdy got=%b exp=0", ifc.pix_rdy_o); end
        @(negedge clk);
        ifc.flush_i = 1'b0; ifc.pix_val_i = 1'b0;
        for (int i = 0; i < 256; i++) src[i] = 8'(8'h40 + i);
        send(64, 0, 1'b0, st, to);
        n_vec++; if (to || wr_we.size() != 18) begin n_err++; $display("FAIL flush_nwr got=%0d exp=18", wr_we.size()); end
        n_vec++; if (wr_addr.size() < 3 || wr_addr[2] !== 4'h0) begin n_err++;
            $display("FAIL flush_restart got=%h exp=0", wr_addr.size() > 2 ? wr_addr[2] : 4'hX); end
        for (int i = 0; i < 16; i++) begin
            n_vec++;
            if (mem[0][i] !== exp_word(i)) begin
                n_err++; $display("FAIL flush_mem%0d got=%h exp=%h", i, mem[0][i], exp_word(i));
            end
        end
        n_vec++; if (done_b.size() != 1 || done_b[0] !== 1'b0) begin n_err++;
            $display("FAIL flush_done got_n=%0d exp=1 on bank 0", done_b.size()); end
    endtask

    task automatic test_reset_mid();
        int st; bit to;
        do_reset();
        for (int i = 0; i < 256; i++) src[i] = 8'(i);
        send(64, 0, 1'b0, st, to);
        @(negedge clk); ifc.rel_i = 2'b01;
        @(negedge clk); ifc.rel_i = 2'b00;
        send(64, 0, 1'b0, st, to);
        n_vec++; if (ifc.full_o !== 2'b10) begin n_err++; $display("FAIL rmid_pre_full got=%b exp=10", ifc.full_o); end
        clear_logs();
        for (int i = 0; i < 256; i++) src[i] = 8'(8'h10 + i);
        send(37, 0, 1'b0, st, to);
        n_vec++; if (to || wr_we.size() != 9 || wr_we[0] !== 2'b01) begin n_err++;
            $display("FAIL rmid_partial got=%0d exp=9 to bank 0", wr_we.size()); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        n_vec++; if (ifc.full_o !== 2'b00 || ifc.we_o !== 2'b00) begin n_err++;
            $display("FAIL rmid_cleared got=%b/%b exp=00/00", ifc.full_o, ifc.we_o); end
        rst = 1'b0;
        clear_logs();
        for (int i = 0; i < 256; i++) src[i] = 8'(8'hC0 + i);
        send(64, 0, 1'b0, st, to);
        n_vec++; if (to || wr_we.size() != 16) begin n_err++; $display("FAIL rmid_nwr got=%0d exp=16", wr_we.size()); end
        for (int i = 0; i < 16 && i < wr_we.size(); i++) begin
            n_vec++;
            if (wr_we[i] !== 2'b01 || wr_addr[i] !== 4'(i) || wr_data[i] !== exp_word(i)) begin
                n_err++;
                $display("FAIL rmid_word%0d got=%b/%h/%h exp=01/%h/%h", i, wr_we[i], wr_addr[i], wr_data[i], i, exp_word(i));
            end
        end
    endtask

    task automatic test_release();
        int st; bit to;
        do_reset();
        @(negedge clk); ifc.rel_i = 2'b10;
        @(negedge clk); ifc.rel_i = 2'b00;
        #1;
        n_vec++; if (ifc.full_o !== 2'b00 || ifc.pix_rdy_o !== 1'b1) begin n_err++;
            $display("FAIL rel_empty got=%b/%b exp=00/1", ifc.full_o, ifc.pix_rdy_o); end
        for (int i = 0; i < 256; i++) src[i] = 8'(8'hFF - i);
        send(128, 0, 1'b0, st, to);
        n_vec++; if (ifc.full_o !== 2'b11) begin n_err++; $display("FAIL rel_both_full got=%b exp=11", ifc.full_o); end
        @(negedge clk); ifc.rel_i = 2'b11;
        @(negedge clk); ifc.rel_i = 2'b00;
        n_vec++; if (ifc.full_o !== 2'b00) begin n_err++; $display("FAIL rel_both got=%b exp=00", ifc.full_o); end
        @(negedge clk); #1;
        n_vec++; if (ifc.pix_rdy_o !== 1'b1) begin n_err++; $display("FAIL rel_both_rdy got=%b exp=1", ifc.pix_rdy_o); end
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0;
        rst = 1'b1;
        ifc.pix_i = 8'h00; ifc.pix_val_i = 1'b0; ifc.flush_i = 1'b0; ifc.rel_i = 2'b00;
        clear_logs();
        test_reset();
        test_one_block();
        test_no_release();
        test_random_gaps();
        test_flush();
        test_reset_mid();
        test_release();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
